codeword_serialiser: RTL and testbench

Downstream neighbour of the per-channel codeword encoder. It captures each variable-length codeword and length pair when `bin_finish` strobes, buffers pairs in a small FIFO, and emits them MSB-first as a one-bit-per-clock stream under a valid/ready handshake. The stream goes to the output packer/link. Codewords are back-to-back with no idle cycles between them while the FIFO holds data.

---
 rtl/codeword_serialiser.sv | 108 ++++++++++
 tb/tb_codeword_serialiser.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/codeword_serialiser.sv
// codeword_serialiser: buffers {codeword,length} pairs in a FIFO and shifts them out MSB-first, one bit per clock.
// Optional feature: define SERIALISER_OVERFLOW_CNT_EN to add the saturating overflow_count output.
module codeword_serialiser #(
    parameter int CW_MAX = 4,
    parameter int LEN_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bin_finish,
    input  logic [CW_MAX-1:0] codeword,
    input  logic [LEN_W-1:0]  length,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              len_err
`ifdef SERIALISER_OVERFLOW_CNT_EN
    ,
    output logic [7:0]        overflow_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_nx, rd_nx;
    logic [CW_MAX-1:0] cw_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem [DEPTH];
    logic [CW_MAX-1:0] shreg, shifted;
    logic [LEN_W-1:0]  bit_idx;
    logic              legal, last, advance, pop, push, drop;

    assign legal     = (length != '0) && (int'(length) <= CW_MAX);
    assign last      = bit_idx == '0;
    assign ser_valid = state == SHIFT;
    assign shifted   = shreg >> bit_idx;
    assign ser_bit   = ser_valid & shifted[0];
    assign ser_last  = ser_valid & last;
    assign wr_nx     = wr_ptr + PW'(push);
    assign rd_nx     = rd_ptr + PW'(pop);

    // Next-state and FIFO pop/push decisions; a pop on the last accepted bit keeps the stream gap-free
    always_comb begin
        advance  = (state == IDLE) || (ser_ready && last);
        pop      = advance && !fifo_empty;
        state_nx = advance ? (fifo_empty ? IDLE : SHIFT) : state;
        push     = bin_finish && legal && (!fifo_full || pop);
        drop     = bin_finish && legal && fifo_full && !pop;
    end

    // State, pointers, registered occupancy flags and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_nx;
            rd_ptr     <= rd_nx;
            fifo_empty <= wr_nx == rd_nx;
            fifo_full  <= (wr_nx[AW] != rd_nx[AW]) && (wr_nx[AW-1:0] == rd_nx[AW-1:0]);
            overflow   <= overflow | drop;
            len_err    <= len_err | (bin_finish & !legal);
        end
    end

    // FIFO storage; contents are don't-care until written, the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            cw_mem[wr_ptr[AW-1:0]]  <= codeword;
            len_mem[wr_ptr[AW-1:0]] <= length;
        end
    end

    // Shift register load on pop, bit index steps down on each accepted bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (pop) begin
            shreg   <= cw_mem[rd_ptr[AW-1:0]];
            bit_idx <= len_mem[rd_ptr[AW-1:0]] - LEN_W'(1);
        end else if (ser_valid && ser_ready) begin
            bit_idx <= bit_idx - LEN_W'(1);
        end
    end

`ifdef SERIALISER_OVERFLOW_CNT_EN
    // Saturating count of pushes dropped because the FIFO was full
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_count <= '0;
        else if (drop && overflow_count != 8'hFF)
            overflow_count <= overflow_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_codeword_serialiser.sv
// tb_codeword_serialiser: scoreboard bench for codeword_serialiser with a queue-based reference model.
module tb_codeword_serialiser;
    localparam int CW_MAX = 4;
    localparam int LEN_W  = 3;
    localparam int DEPTH  = 4;

    logic              clk = 0;
    logic              rst = 1;
    logic              bin_finish = 0;
    logic [CW_MAX-1:0] codeword = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              ser_ready = 0;
    logic              ser_valid, ser_bit, ser_last, fifo_full, fifo_empty, overflow, len_err;
`ifdef SERIALISER_OVERFLOW_CNT_EN
    logic [7:0]        overflow_count;
`endif

    codeword_serialiser #(.CW_MAX(CW_MAX), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bin_finish(bin_finish), .codeword(codeword), .length(length),
        .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_last(ser_last),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow), .len_err(len_err)
`ifdef SERIALISER_OVERFLOW_CNT_EN
        , .overflow_count(overflow_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic b; logic l;} exp_t;
    exp_t exp_q[$];
    int   lq[$];
    int   rem = 0;
    bit   m_ovf = 0, m_lerr = 0;
    int   m_cnt = 0;
    int   n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented bit with the scoreboard head; pop when it is accepted
    always @(negedge clk) begin
        if (!rst && ser_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                chk("ser_bit", ser_bit, exp_q[0].b);
                chk("ser_last", ser_last, exp_q[0].l);
                if (ser_ready) void'(exp_q.pop_front());
            end
        end
    end

    function automatic void model_clear();
        exp_q.delete();
        lq.delete();
        rem = 0;
        m_ovf = 0;
        m_lerr = 0;
        m_cnt = 0;
    endfunction

    // Reference model: rem = bits still to send of the current codeword, lq = lengths waiting in the FIFO
    function automatic void model_edge(input logic bf, input logic [3:0] cw, input logic [2:0] len, input logic rdy);
        bit pop = 0;
        if (rem == 0) pop = lq.size() > 0;
        else if (rdy) begin
            if (rem == 1) pop = lq.size() > 0;
            rem--;
        end
        if (pop) rem = lq.pop_front();
        if (bf) begin
            if (len < 1 || len > CW_MAX) m_lerr = 1;
            else if (lq.size() < DEPTH) begin
                lq.push_back(int'(len));
                for (int i = int'(len) - 1; i >= 0; i--) exp_q.push_back('{cw[i], i == 0});
            end else begin
                m_ovf = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endfunction

    task automatic step(input logic bf, input logic [3:0] cw, input logic [2:0] len, input logic rdy);
        @(posedge clk);
        #1;
        bin_finish = bf;
        codeword = cw;
        length = len;
        ser_ready = rdy;
        @(negedge clk);
        chk("ser_valid", ser_valid, rem > 0);
        chk("fifo_empty", fifo_empty, lq.size() == 0);
        chk("fifo_full", fifo_full, lq.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("len_err", len_err, m_lerr);
`ifdef SERIALISER_OVERFLOW_CNT_EN
        chk("overflow_count", overflow_count, m_cnt);
`endif
        model_edge(bf, cw, len, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        bin_finish = 0;
        #1;
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_bit", ser_bit, 0);
        chk("rst_ser_last", ser_last, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_len_err", len_err, 0);
`ifdef SERIALISER_OVERFLOW_CNT_EN
        chk("rst_overflow_count", overflow_count, 0);
`endif
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rem > 0 || lq.size() > 0) && n < 200) begin
            step(0, 4'h0, 3'd0, 1);
            n++;
        end
        if (rem > 0 || lq.size() > 0) chk("drain_timeout", n, -1);
        step(0, 4'h0, 3'd0, 1);
        step(0, 4'h0, 3'd0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        do_reset();
        step(1, 4'b0101, 3'd3, 1);
        drain();
        step(1, 4'b0001, 3'd2, 1);
        step(1, 4'b0001, 3'd1, 1);
        step(1, 4'b0000, 3'd4, 1);
        drain();
        for (int i = 0; i < 14; i++)
            step(i == 0, 4'b0110, 3'd3, (i % 4 == 0) || (i % 4 == 3));
        drain();
        for (int i = 0; i < DEPTH + 2; i++)
            step(1, 4'($urandom_range(0, 15)), 3'($urandom_range(1, CW_MAX)), 0);
        step(0, 4'h0, 3'd0, 0);
        chk("full_after_depth", fifo_full, 1);
        chk("overflow_after_drop", overflow, 1);
        drain();
        do_reset();
        step(1, 4'hF, 3'd0, 1);
        step(1, 4'hF, 3'd5, 1);
        step(0, 4'h0, 3'd0, 1);
        chk("len_err_set", len_err, 1);
        chk("len_err_empty", fifo_empty, 1);
        step(1, 4'b0001, 3'd4, 1);
        step(0, 4'h0, 3'd0, 1);
        step(0, 4'h0, 3'd0, 1);
        step(0, 4'h0, 3'd0, 1);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 4'h0, 3'd0, 1);
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            step($urandom_range(0, 99) < 40, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, CW_MAX)),
                 $urandom_range(0, 99) < 70);
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
